// File: rtl/llc_sram_data.sv
// Behavioural LLC data-way SRAM: N request ports, byte-enabled writes,
// read-before-write, fixed-latency read pipeline and selectable power-up content.
module llc_sram_data #(
    parameter int unsigned  NumWords    = 1024,
    parameter int unsigned  DataWidth   = 128,
    parameter int unsigned  ByteWidth   = 8,
    parameter int unsigned  NumPorts    = 2,
    parameter int unsigned  Latency     = 1,
    parameter string        SimInit     = "none",
    parameter bit           PrintSimCfg = 1'b0,
    localparam int unsigned AddrWidth   = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth     = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumPorts-1:0]                  req_i,
    input  logic [NumPorts-1:0]                  we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]     be_i,
    output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
);

    if (NumWords == 0 || DataWidth == 0 || ByteWidth == 0 || NumPorts == 0) begin : g_bad_cfg
        $error("llc_sram_data: NumWords, DataWidth, ByteWidth and NumPorts must be >= 1");
    end
    if (Latency == 0) begin : g_bad_latency
        $error("llc_sram_data: Latency must be >= 1");
    end
    if (PrintSimCfg) begin : g_print_cfg
        $info("llc_sram_data: NumWords=%0d DataWidth=%0d ByteWidth=%0d NumPorts=%0d Latency=%0d SimInit=%s AddrWidth=%0d BeWidth=%0d",
              NumWords, DataWidth, ByteWidth, NumPorts, Latency, SimInit, AddrWidth, BeWidth);
    end

    localparam int unsigned InitMode = (SimInit == "zeros")  ? 1 :
                                       (SimInit == "ones")   ? 2 :
                                       (SimInit == "random") ? 3 : 0;

    typedef logic [NumWords-1:0][DataWidth-1:0] mem_t;

    // Power-up image; "random" is a fixed LFSR pattern so runs are reproducible.
    function automatic mem_t init_mem();
        mem_t        m;
        logic [31:0] s;
        s = 32'h2545_F491;
        for (int w = 0; w < int'(NumWords); w++) begin
            case (InitMode)
                1: m[w] = '0;
                2: m[w] = '1;
                3: begin
                    for (int b = 0; b < int'(DataWidth); b++) begin
                        m[w][b] = s[0];
                        s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
                    end
                end
                default: m[w] = 'x;
            endcase
        end
        return m;
    endfunction

    mem_t mem_q = init_mem();

    logic [NumPorts-1:0]                in_range;
    logic [NumPorts-1:0]                wr_en;
    logic [NumPorts-1:0]                rd_en;
    logic [NumPorts-1:0][DataWidth-1:0] rd_val;
    logic [NumPorts-1:0][DataWidth-1:0] wmask;

    always_comb begin
        in_range = '0;
        wr_en    = '0;
        rd_en    = '0;
        rd_val   = '0;
        wmask    = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            in_range[p] = 32'(addr_i[p]) < NumWords;
            wr_en[p]    = !rst_i && req_i[p] && we_i[p] && in_range[p];
            rd_en[p]    = !rst_i && req_i[p] && !we_i[p];
            rd_val[p]   = in_range[p] ? mem_q[addr_i[p]] : '0;
            for (int i = 0; i < int'(DataWidth); i++) begin
                wmask[p][i] = be_i[p][i / int'(ByteWidth)];
            end
        end
    end

    // Later ports are applied last, so the highest-index port wins each lane.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (wr_en[p]) begin
                for (int i = 0; i < int'(DataWidth); i++) begin
                    if (wmask[p][i]) begin
                        mem_q[addr_i[p]][i] <= wdata_i[p][i];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        logic [Latency-1:0]                vld_q, vld_d;
        logic [Latency-1:0][DataWidth-1:0] data_q, data_d;

        // Stages only advance behind a valid read, so the last stage holds its value.
        always_comb begin
            vld_d  = (vld_q << 1) | Latency'(rd_en[p]);
            data_d = data_q;
            if (rd_en[p]) begin
                data_d[0] = rd_val[p];
            end
            for (int k = 1; k < int'(Latency); k++) begin
                if (vld_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q  <= '0;
                data_q <= '0;
            end else begin
                vld_q  <= vld_d;
                data_q <= data_d;
            end
        end

        assign rdata_o[p] = data_q[Latency-1];
    end

endmodule

// File: tb/tb_llc_sram_data.sv
// Directed bench for llc_sram_data: a 2-port/12-word/latency-1 instance and
// a 1-port/16-word/latency-3 instance, both 64-bit words with 8-bit lanes.
module tb_llc_sram_data;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic            a_rst;
    logic [1:0]      a_req, a_we;
    logic [1:0][3:0] a_addr;
    logic [1:0][63:0] a_wdata, a_rdata;
    logic [1:0][7:0] a_be;

    logic            b_rst;
    logic [0:0]      b_req, b_we;
    logic [0:0][3:0] b_addr;
    logic [0:0][63:0] b_wdata, b_rdata;
    logic [0:0][7:0] b_be;

    llc_sram_data #(
        .NumWords(12), .DataWidth(64), .ByteWidth(8), .NumPorts(2),
        .Latency(1), .SimInit("zeros"), .PrintSimCfg(1'b0)
    ) u_dut_a (
        .clk_i(clk), .rst_i(a_rst), .req_i(a_req), .we_i(a_we),
        .addr_i(a_addr), .wdata_i(a_wdata), .be_i(a_be), .rdata_o(a_rdata)
    );

    llc_sram_data #(
        .NumWords(16), .DataWidth(64), .ByteWidth(8), .NumPorts(1),
        .Latency(3), .SimInit("zeros"), .PrintSimCfg(1'b0)
    ) u_dut_b (
        .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .we_i(b_we),
        .addr_i(b_addr), .wdata_i(b_wdata), .be_i(b_be), .rdata_o(b_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_op(input int p, input logic we, input logic [3:0] addr,
                        input logic [63:0] d, input logic [7:0] be);
        a_req[p]   = 1'b1;
        a_we[p]    = we;
        a_addr[p]  = addr;
        a_wdata[p] = d;
        a_be[p]    = be;
    endtask

    task automatic a_idle();
        a_req = '0;
        a_we  = '0;
    endtask

    task automatic b_op(input logic we, input logic [3:0] addr, input logic [63:0] d);
        b_req[0]   = 1'b1;
        b_we[0]    = we;
        b_addr[0]  = addr;
        b_wdata[0] = d;
        b_be[0]    = 8'hFF;
    endtask

    task automatic b_idle();
        b_req = '0;
        b_we  = '0;
    endtask

    initial begin
        a_rst = 1'b1; a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_rst = 1'b1; b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0;
        step();
        step();
        chk("reset_a0", a_rdata[0], 64'h0);
        chk("reset_a1", a_rdata[1], 64'h0);
        chk("reset_b", b_rdata[0], 64'h0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Full write then read, with hold through idle cycles
        a_op(0, 1'b1, 4'd3, 64'h0123_4567_89AB_CDEF, 8'hFF);
        step(); a_idle();
        chk("write_keeps_rdata", a_rdata[0], 64'h0);
        a_op(0, 1'b0, 4'd3, 64'h0, 8'h00);
        step(); a_idle();
        chk("full_read", a_rdata[0], 64'h0123_4567_89AB_CDEF);
        step();
        step();
        chk("idle_hold", a_rdata[0], 64'h0123_4567_89AB_CDEF);

        // Partial byte-enable write
        a_op(0, 1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        step(); a_idle();
        chk("be_write_keeps_rdata", a_rdata[0], 64'h0123_4567_89AB_CDEF);
        a_op(0, 1'b0, 4'd3, 64'h0, 8'h00);
        step(); a_idle();
        chk("be_read", a_rdata[0], 64'h0123_4567_FFFF_FFFF);

        // Read-before-write across ports
        a_op(0, 1'b1, 4'd5, 64'hAA, 8'hFF);
        a_op(1, 1'b0, 4'd5, 64'h0, 8'h00);
        step(); a_idle();
        chk("rbw_old_data", a_rdata[1], 64'h0);
        chk("rbw_p0_hold", a_rdata[0], 64'h0123_4567_FFFF_FFFF);
        a_op(1, 1'b0, 4'd5, 64'h0, 8'h00);
        step(); a_idle();
        chk("rbw_new_data", a_rdata[1], 64'hAA);

        // Two ports writing one address: higher port wins per enabled lane
        a_op(0, 1'b1, 4'd7, 64'h1111_1111_1111_1111, 8'hFF);
        a_op(1, 1'b1, 4'd7, 64'h2222_2222_2222_2222, 8'h0F);
        step(); a_idle();
        a_op(0, 1'b0, 4'd7, 64'h0, 8'h00);
        step(); a_idle();
        chk("write_conflict", a_rdata[0], 64'h1111_1111_2222_2222);

        // Out-of-range accesses
        a_op(0, 1'b1, 4'd13, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        a_op(1, 1'b1, 4'd12, 64'hCAFE_F00D_CAFE_F00D, 8'hFF);
        step(); a_idle();
        a_op(0, 1'b0, 4'd13, 64'h0, 8'h00);
        a_op(1, 1'b0, 4'd12, 64'h0, 8'h00);
        step(); a_idle();
        chk("oor_read_13", a_rdata[0], 64'h0);
        chk("oor_read_12", a_rdata[1], 64'h0);
        a_op(0, 1'b0, 4'd11, 64'h0, 8'h00);
        a_op(1, 1'b0, 4'd5, 64'h0, 8'h00);
        step(); a_idle();
        chk("oor_addr11_kept", a_rdata[0], 64'h0);
        chk("oor_addr5_kept", a_rdata[1], 64'hAA);
        a_op(0, 1'b0, 4'd4, 64'h0, 8'h00);
        a_op(1, 1'b0, 4'd3, 64'h0, 8'h00);
        step(); a_idle();
        chk("oor_addr4_kept", a_rdata[0], 64'h0);
        chk("oor_addr3_kept", a_rdata[1], 64'h0123_4567_FFFF_FFFF);

        // Reset mid-operation; requests during reset are dropped
        a_op(0, 1'b0, 4'd3, 64'h0, 8'h00);
        step(); a_idle();
        chk("pre_reset_read", a_rdata[0], 64'h0123_4567_FFFF_FFFF);
        a_rst = 1'b1;
        a_op(0, 1'b0, 4'd3, 64'h0, 8'h00);
        a_op(1, 1'b1, 4'd3, 64'h0, 8'hFF);
        step(); a_idle();
        a_rst = 1'b0;
        chk("reset_clears_p0", a_rdata[0], 64'h0);
        chk("reset_clears_p1", a_rdata[1], 64'h0);
        step();
        chk("reset_read_ignored", a_rdata[0], 64'h0);
        a_op(0, 1'b0, 4'd3, 64'h0, 8'h00);
        step(); a_idle();
        chk("memory_kept_after_reset", a_rdata[0], 64'h0123_4567_FFFF_FFFF);

        // Latency-3 back-to-back reads
        b_op(1'b1, 4'd1, 64'd1);
        step();
        b_op(1'b1, 4'd2, 64'd2);
        step();
        b_op(1'b0, 4'd1, 64'd0);
        step();
        chk("lat3_edge1", b_rdata[0], 64'h0);
        b_op(1'b0, 4'd2, 64'd0);
        step(); b_idle();
        chk("lat3_edge2", b_rdata[0], 64'h0);
        step();
        chk("lat3_first", b_rdata[0], 64'd1);
        step();
        chk("lat3_second", b_rdata[0], 64'd2);
        step();
        chk("lat3_hold", b_rdata[0], 64'd2);

        // Reset discards a read still in the pipeline
        b_op(1'b0, 4'd1, 64'd0);
        step(); b_idle();
        chk("inflight_hold1", b_rdata[0], 64'd2);
        step();
        chk("inflight_hold2", b_rdata[0], 64'd2);
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        chk("inflight_reset", b_rdata[0], 64'h0);
        step();
        chk("inflight_discard1", b_rdata[0], 64'h0);
        step();
        chk("inflight_discard2", b_rdata[0], 64'h0);
        b_op(1'b0, 4'd2, 64'd0);
        step(); b_idle();
        step();
        step();
        chk("lat3_memory_kept", b_rdata[0], 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
